// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 16x8 FIFO: issues rd_en, absorbs the 1-cycle read latency in a 2-entry skid buffer,
// m_valid two cycles after fifo_empty falls, 1 word/cycle; m_ready low stalls after 2 outstanding words. Burst/flush FSM under RD_BURST_EN.
module fifo_rd_ctrl #(
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_WIDTH-1:0]  fifo_data_out,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_counter,
  output logic                  rd_en,
  output logic [MEM_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           rd_count
`ifdef RD_BURST_EN
  ,
  input  logic                  flush,
  output logic                  burst_active
`endif
);

  logic [1:0]           occ;
  logic                 inflight;
  logic [MEM_WIDTH-1:0] skid0;
  logic [MEM_WIDTH-1:0] skid1;
  logic                 pop;
  logic                 run;
  logic [1:0]           occ_pop;
  logic [2:0]           pending;

  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = skid0;
  assign occ_pop = occ - {1'b0, pop};

  // Words held or arriving after this edge; a new read is allowed only if that stays below 2.
  assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en   = ~rst & run & ~fifo_empty & (pending < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      skid0    <= '0;
      skid1    <= '0;
      rd_count <= 16'd0;
    end else begin
      inflight <= rd_en;
      occ      <= occ_pop + {1'b0, inflight};
      if (pop)
        rd_count <= rd_count + 16'd1;
      // Tail slot is wherever the buffer ends after this edge's pop.
      if (inflight && occ_pop == 2'd0)
        skid0 <= fifo_data_out;
      else if (pop)
        skid0 <= skid1;
      if (inflight && occ_pop == 2'd1)
        skid1 <= fifo_data_out;
    end
  end

`ifdef RD_BURST_EN
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] BURST_LEN_W = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] ONE_W       = (ADDR_WIDTH+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] burst_cnt;
  logic [ADDR_WIDTH:0] burst_cnt_nxt;

  assign run = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (fifo_counter >= BURST_LEN_W) begin
          state_nxt     = BURST;
          burst_cnt_nxt = BURST_LEN_W;
        end else if (flush && !fifo_empty) begin
          state_nxt = DRAIN;
        end
      end
      BURST: begin
        if (rd_en) begin
          burst_cnt_nxt = burst_cnt - ONE_W;
          if (burst_cnt == ONE_W)
            state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (fifo_empty)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      burst_cnt    <= burst_cnt_nxt;
      burst_active <= (state_nxt != IDLE);
    end
  end
`else
  localparam int unused_burst_len = BURST_LEN;
  logic unused_counter;

  assign run            = 1'b1;
  assign unused_counter = ^fifo_counter;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural 16x8 FIFO in front, scoreboard queue checked against the output stream.
module tb_fifo_rd_ctrl;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_empty;
  logic [AW:0]   fifo_counter;
  logic          rd_en;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   rd_count;
`ifdef RD_BURST_EN
  logic          flush;
  logic          burst_active;
`endif

  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  mem [16];
  logic [AW-1:0] wp, rp;
  wire           fifo_wr = wr_en && (fifo_counter != 5'd16);
  wire           fifo_rd = rd_en && !fifo_empty;

  always #5 clk = ~clk;

  fifo_rd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_counter (fifo_counter),
    .rd_en        (rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .rd_count     (rd_count)
`ifdef RD_BURST_EN
    ,
    .flush        (flush),
    .burst_active (burst_active)
`endif
  );

  // Behavioural FIFO with registered read data.
  assign fifo_empty = (fifo_counter == 5'd0);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; fifo_counter <= '0; fifo_data_out <= '0;
    end else begin
      if (fifo_wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd) begin
        fifo_data_out <= mem[rp];
        rp            <= rp + 4'd1;
      end
      fifo_counter <= fifo_counter + 5'(fifo_wr) - 5'(fifo_rd);
    end
  end

  int n_vec = 0, n_err = 0;
  int cyc = 0, rd_acc = 0, pops = 0, vld_cycles = 0, first_pop = 0, last_pop = 0;
  bit stall_seen = 0, data_moved = 0;
  logic [W-1:0] held;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en && !fifo_empty) rd_acc++;
      if (m_valid) vld_cycles++;
      if (m_valid && !m_ready) begin
        if (stall_seen && m_data !== held) data_moved = 1;
        held = m_data;
        stall_seen = 1;
      end else begin
        stall_seen = 0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_val("extra_word", 32'(m_data), 32'hFFFF_FFFF);
        else check_val("data", 32'(m_data), 32'(exp_q.pop_front()));
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rd_acc = 0; pops = 0; vld_cycles = 0; first_pop = 0; last_pop = 0;
    stall_seen = 0; data_moved = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    exp_q.delete();
    clear_stats();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (pops < n && c < budget) begin
      tick();
      c++;
    end
    if (pops < n) check_val("pop_timeout", 32'(pops), 32'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, j, c, sent;
`ifdef RD_BURST_EN
    int base;
    bit seen;
    flush = 1'b0;
`endif
    wr_en = 1'b0; wr_data = '0; m_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_val("rst_m_valid", 32'(m_valid), 0);
    check_val("rst_rd_en", 32'(rd_en), 0);
    check_val("rst_rd_count", 32'(rd_count), 0);
    check_val("rst_m_data", 32'(m_data), 0);
    do_reset();

    // Single word: latency 2 from fifo_empty falling.
    m_ready = 1'b1;
    write_word(8'hA5);
    k = cyc;
    check_val("single_nonempty", 32'(fifo_empty), 0);
    j = -1;
    c = 0;
    while (j < 0 && c < 10) begin
      if (m_valid) j = cyc;
      else tick();
      c++;
    end
    check_val("single_latency", 32'(j - k), 2);
    repeat (6) tick();
    check_val("single_reads", 32'(rd_acc), 1);
    check_val("single_vld_cycles", 32'(vld_cycles), 1);
    check_val("single_rd_count", 32'(rd_count), 1);

    // Streaming with no bubbles.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    wait_pops(16, 60);
    check_val("stream_pops", 32'(pops), 16);
    check_val("stream_span", 32'(last_pop - first_pop), 15);
    check_val("stream_rd_count", 32'(rd_count), 16);
    check_val("stream_q_left", 32'(exp_q.size()), 0);

    // Backpressure: only two reads outstanding, head held.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    repeat (10) tick();
    check_val("bp_reads", 32'(rd_acc), 2);
    check_val("bp_m_valid", 32'(m_valid), 1);
    check_val("bp_m_data", 32'(m_data), 0);
    check_val("bp_stable", 32'(data_moved), 0);
    check_val("bp_fifo_cnt", 32'(fifo_counter), 14);
    m_ready = 1'b1;
    wait_pops(16, 80);
    check_val("bp_pops", 32'(pops), 16);
    check_val("bp_rd_count", 32'(rd_count), 16);
    check_val("bp_q_left", 32'(exp_q.size()), 0);

    // Random ready with concurrent writes.
    do_reset();
    sent = 0;
    c = 0;
    while ((sent < 200 || pops < 200) && c < 5000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && fifo_counter < 5'd16 && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      c++;
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    check_val("rand_pops", 32'(pops), 200);
    check_val("rand_rd_count", 32'(rd_count), 200);
    check_val("rand_q_left", 32'(exp_q.size()), 0);
    check_val("rand_stable", 32'(data_moved), 0);

    // Asynchronous reset mid-stream.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_word(8'(8'h40 + i));
    check_val("mid_busy", 32'(m_valid), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("mid_m_valid", 32'(m_valid), 0);
    check_val("mid_rd_count", 32'(rd_count), 0);
    check_val("mid_occ", 32'(dut.occ), 0);
    check_val("mid_rd_en", 32'(rd_en), 0);
    check_val("mid_m_data", 32'(m_data), 0);
    do_reset();

`ifdef RD_BURST_EN
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(8'(8'h10 + i));
    repeat (6) tick();
    check_val("burst_below_reads", 32'(rd_acc), 0);
    check_val("burst_below_active", 32'(burst_active), 0);
    write_word(8'h13);
    repeat (12) tick();
    check_val("burst_reads", 32'(rd_acc), 4);
    check_val("burst_pops", 32'(pops), 4);
    check_val("burst_idle", 32'(burst_active), 0);
    check_val("burst_empty", 32'(fifo_empty), 1);
    base = rd_acc;
    write_word(8'h20);
    write_word(8'h21);
    repeat (5) tick();
    check_val("flush_pre_reads", 32'(rd_acc - base), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    repeat (10) begin
      if (burst_active) seen = 1;
      tick();
    end
    check_val("flush_seen_active", 32'(seen), 1);
    check_val("flush_pops", 32'(pops), 6);
    check_val("flush_active_low", 32'(burst_active), 0);
    check_val("flush_q_left", 32'(exp_q.size()), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
